// File: rtl/fft_sdf_stage_ctrl.sv
// Control for one single-path delay-feedback FFT stage: step counter, fill/run/flush
// sequencing, twiddle ROM addressing and ROM-latency-matched output flags.
module fft_sdf_stage_ctrl #(
    parameter int LOG2N   = 9,
    parameter int ROM_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_flush,
    output logic             o_ready,
    output logic [LOG2N-2:0] o_rom_addr,
    output logic             o_bf_sel,
    output logic             o_rot_en,
    output logic             o_out_valid,
    output logic             o_frame_done,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [LOG2N-1:0] HALF_M1 = {1'b0, {(LOG2N-1){1'b1}}};
    localparam logic [LOG2N-1:0] LAST    = {LOG2N{1'b1}};

    logic [1:0]       state, state_nxt;
    logic [LOG2N-1:0] cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic             step;

    logic [ROM_LAT:0] vld_pipe, rot_pipe, fd_pipe;

    assign o_ready = (state != S_FLUSH);
    assign o_busy  = (state != S_IDLE);
    assign step    = (i_valid && o_ready) || (state == S_FLUSH);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        if (((state == S_FILL) || (state == S_RUN)) && i_flush)
            pend_nxt = 1'b1;
        if (step) begin
            cnt_nxt = cnt + 1'b1;
            case (state)
                S_IDLE:  state_nxt = S_FILL;
                S_FILL:  if (cnt == HALF_M1) state_nxt = S_RUN;
                S_RUN: begin
                    // A same-cycle flush request counts as if it were already pending
                    if ((cnt == LAST) && (pend || i_flush)) begin
                        state_nxt = S_FLUSH;
                        pend_nxt  = 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (cnt == HALF_M1) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Stage-0 registers: ROM address and butterfly select hold between steps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bf_sel   <= 1'b0;
            o_rom_addr <= '0;
        end else if (step) begin
            o_bf_sel   <= cnt[LOG2N-1];
            o_rom_addr <= cnt[LOG2N-1] ? '0 : cnt[LOG2N-2:0];
        end
    end

    // Flag pipeline keeps running across FLUSH->IDLE so in-flight outputs still emerge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            rot_pipe <= '0;
            fd_pipe  <= '0;
        end else begin
            vld_pipe[0] <= step && ((state == S_RUN) || (state == S_FLUSH));
            rot_pipe[0] <= ~cnt[LOG2N-1];
            fd_pipe[0]  <= (cnt == HALF_M1);
            for (int i = ROM_LAT; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rot_pipe[i] <= rot_pipe[i-1];
                fd_pipe[i]  <= fd_pipe[i-1];
            end
        end
    end

    assign o_out_valid  = vld_pipe[ROM_LAT];
    assign o_rot_en     = vld_pipe[ROM_LAT] & rot_pipe[ROM_LAT];
    assign o_frame_done = vld_pipe[ROM_LAT] & fd_pipe[ROM_LAT];

endmodule
